// File: rtl/car_sprite_reader.sv
// Read-side engine for the car sprite RAM: frame-synchronous register commit,
// animation frame selection and a 3-stage address/colour-key overlay pipeline.
module car_sprite_reader #(
  parameter int              CD         = 12,
  parameter int              SPR_W_BITS = 5,
  parameter int              SPR_H_BITS = 5,
  parameter int              FRAME_BITS = 1,
  parameter logic [CD-1:0]   KEY_COLOR  = 12'hF0F,
  parameter int              ADDR_WIDTH = FRAME_BITS + SPR_H_BITS + SPR_W_BITS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [10:0]           x,
  input  logic [10:0]           y,
  input  logic                  frame_start,
  input  logic                  wr_en,
  input  logic [1:0]            wr_addr,
  input  logic [31:0]           wr_data,
  output logic [ADDR_WIDTH-1:0] ram_addr_r,
  input  logic [CD-1:0]         ram_dout,
  input  logic [CD-1:0]         si_rgb,
  output logic [CD-1:0]         so_rgb
);

  logic [10:0]           xOrgSh_q, yOrgSh_q, xOrg_q, yOrg_q;
  logic                  enableSh_q, animateSh_q, enable_q, animate_q;
  logic [7:0]            periodSh_q, period_q;
  logic [FRAME_BITS-1:0] frameSelSh_q, frameSel_q;
  logic [7:0]            animCnt_q, animCnt_d;
  logic [FRAME_BITS-1:0] curFrame_q, curFrame_d;
  logic [7:0]            animLimit;
  logic [11:0]           xRel, yRel;
  logic                  hit1_d, hit1_q, hit2_q;
  logic [ADDR_WIDTH-1:0] ramAddr_q;
  logic [CD-1:0]         si1_q, si2_q, soRgb_q;
  logic                  unusedWrData;

  assign unusedWrData = ^wr_data[31:11];

  // Bus writes only ever land in the shadow set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xOrgSh_q     <= '0;
      yOrgSh_q     <= '0;
      enableSh_q   <= 1'b0;
      animateSh_q  <= 1'b0;
      periodSh_q   <= '0;
      frameSelSh_q <= '0;
    end else if (wr_en) begin
      case (wr_addr)
        2'd0: xOrgSh_q <= wr_data[10:0];
        2'd1: yOrgSh_q <= wr_data[10:0];
        2'd2: begin
          enableSh_q  <= wr_data[0];
          animateSh_q <= wr_data[1];
          periodSh_q  <= wr_data[9:2];
        end
        default: frameSelSh_q <= wr_data[FRAME_BITS-1:0];
      endcase
    end
  end

  // Non-blocking semantics give the active copy the pre-write shadow value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xOrg_q     <= '0;
      yOrg_q     <= '0;
      enable_q   <= 1'b0;
      animate_q  <= 1'b0;
      period_q   <= '0;
      frameSel_q <= '0;
    end else if (frame_start) begin
      xOrg_q     <= xOrgSh_q;
      yOrg_q     <= yOrgSh_q;
      enable_q   <= enableSh_q;
      animate_q  <= animateSh_q;
      period_q   <= periodSh_q;
      frameSel_q <= frameSelSh_q;
    end
  end

  // A period of 0 is treated as 1, so the limit never underflows.
  assign animLimit = (period_q == 8'd0) ? 8'd0 : period_q - 8'd1;

  always_comb begin
    animCnt_d  = animCnt_q;
    curFrame_d = curFrame_q;
    if (!animate_q) begin
      animCnt_d  = '0;
      curFrame_d = frameSel_q;
    end else if (frame_start) begin
      if (animCnt_q >= animLimit) begin
        animCnt_d  = '0;
        curFrame_d = curFrame_q + FRAME_BITS'(1);
      end else begin
        animCnt_d = animCnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      animCnt_q  <= '0;
      curFrame_q <= '0;
    end else begin
      animCnt_q  <= animCnt_d;
      curFrame_q <= curFrame_d;
    end
  end

  // Pixels left of / above the origin wrap to large values and miss.
  assign xRel   = {1'b0, x} - {1'b0, xOrg_q};
  assign yRel   = {1'b0, y} - {1'b0, yOrg_q};
  assign hit1_d = enable_q && (xRel[11:SPR_W_BITS] == '0) && (yRel[11:SPR_H_BITS] == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ramAddr_q <= '0;
      hit1_q    <= 1'b0;
      hit2_q    <= 1'b0;
      si1_q     <= '0;
      si2_q     <= '0;
      soRgb_q   <= '0;
    end else begin
      ramAddr_q <= {curFrame_q, yRel[SPR_H_BITS-1:0], xRel[SPR_W_BITS-1:0]};
      hit1_q    <= hit1_d;
      si1_q     <= si_rgb;
      hit2_q    <= hit1_q;
      si2_q     <= si1_q;
      soRgb_q   <= (hit2_q && (ram_dout != KEY_COLOR)) ? ram_dout : si2_q;
    end
  end

  assign ram_addr_r = ramAddr_q;
  assign so_rgb     = soRgb_q;

endmodule

// File: tb/tb_car_sprite_reader.sv
// Directed bench for car_sprite_reader with a 1-cycle-latency sprite RAM model.
module tb_car_sprite_reader;

  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic [10:0] xPos = '0, yPos = '0;
  logic        frameStart = 1'b0;
  logic        wrEn = 1'b0;
  logic [1:0]  wrAddr = '0;
  logic [31:0] wrData = '0;
  logic [10:0] ramAddr;
  logic [11:0] ramDout = '0;
  logic [11:0] siRgb = '0;
  logic [11:0] soRgb;
  logic [11:0] mem [0:2047];

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  car_sprite_reader dut (
    .clk         (clk),
    .reset_n     (resetN),
    .x           (xPos),
    .y           (yPos),
    .frame_start (frameStart),
    .wr_en       (wrEn),
    .wr_addr     (wrAddr),
    .wr_data     (wrData),
    .ram_addr_r  (ramAddr),
    .ram_dout    (ramDout),
    .si_rgb      (siRgb),
    .so_rgb      (soRgb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ramDout <= mem[ramAddr];

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [10:0] xv, input logic [10:0] yv, input logic [11:0] si);
    xPos  = xv;
    yPos  = yv;
    siRgb = si;
  endtask

  task automatic writeReg(input logic [1:0] a, input logic [31:0] d);
    wrEn   = 1'b1;
    wrAddr = a;
    wrData = d;
    step();
    wrEn   = 1'b0;
  endtask

  task automatic frameTick();
    frameStart = 1'b1;
    step();
    frameStart = 1'b0;
    step();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checkCount++;
    assert (obs === expv) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  initial begin
    logic [10:0] animExp [6];
    logic [10:0] zeroExp [4];
    animExp = '{11'h000, 11'h000, 11'h400, 11'h400, 11'h400, 11'h000};
    zeroExp = '{11'h000, 11'h400, 11'h000, 11'h400};

    for (int i = 0; i < 2048; i++) mem[i] = 12'h0A0;
    mem[5]      = 12'hF0F;
    mem[11'h413] = 12'h0B1;

    // Reset behaviour and the 3-cycle passthrough after release
    applyStimulus(11'd0, 11'd0, 12'h123);
    #2 resetN = 1'b0;
    step(2);
    checkOutput("resetSo", 32'(soRgb), 32'h0);
    checkOutput("resetAddr", 32'(ramAddr), 32'h0);
    resetN = 1'b1;
    step(2);
    checkOutput("releaseEdge2", 32'(soRgb), 32'h0);
    step();
    checkOutput("releaseEdge3", 32'(soRgb), 32'h123);

    // Positioning
    writeReg(2'd0, 32'd100);
    writeReg(2'd1, 32'd50);
    writeReg(2'd2, 32'd1);
    frameTick();
    applyStimulus(11'd100, 11'd50, 12'h111);
    step();
    checkOutput("originAddr", 32'(ramAddr), 32'h000);
    step(2);
    checkOutput("originPixel", 32'(soRgb), 32'h0A0);
    applyStimulus(11'd131, 11'd81, 12'h112);
    step();
    checkOutput("cornerAddr", 32'(ramAddr), 32'h3FF);
    applyStimulus(11'd99, 11'd50, 12'h222);
    step(3);
    checkOutput("leftMiss", 32'(soRgb), 32'h222);
    applyStimulus(11'd132, 11'd50, 12'h333);
    step(3);
    checkOutput("rightMiss", 32'(soRgb), 32'h333);

    // Transparency and exact latency
    applyStimulus(11'd105, 11'd50, 12'h444);
    step(3);
    checkOutput("keyTransparent", 32'(soRgb), 32'h444);
    applyStimulus(11'd106, 11'd50, 12'h555);
    step(2);
    checkOutput("latencyEdge2", 32'(soRgb), 32'h444);
    step();
    checkOutput("latencyEdge3", 32'(soRgb), 32'h0A0);

    // Shadowing
    writeReg(2'd0, 32'd200);
    applyStimulus(11'd100, 11'd50, 12'h666);
    step(3);
    checkOutput("shadowHold", 32'(soRgb), 32'h0A0);
    frameTick();
    applyStimulus(11'd100, 11'd50, 12'h667);
    step(3);
    checkOutput("shadowCommitMiss", 32'(soRgb), 32'h667);
    applyStimulus(11'd210, 11'd50, 12'h600);
    step();
    checkOutput("newOriginAddr", 32'(ramAddr), 32'h00A);
    wrEn = 1'b1; wrAddr = 2'd0; wrData = 32'd300; frameStart = 1'b1;
    step();
    wrEn = 1'b0; frameStart = 1'b0;
    step();
    checkOutput("coincidentHold", 32'(ramAddr), 32'h00A);
    frameTick();
    applyStimulus(11'd310, 11'd50, 12'h601);
    step();
    checkOutput("coincidentLater", 32'(ramAddr), 32'h00A);
    applyStimulus(11'd210, 11'd50, 12'h6AB);
    step(3);
    checkOutput("coincidentOldMiss", 32'(soRgb), 32'h6AB);

    // Animation with period 3, then period 0, then manual frame select
    applyStimulus(11'd300, 11'd50, 12'h000);
    writeReg(2'd2, 32'h0F);
    frameTick();
    for (int i = 0; i < 6; i++) begin
      frameTick();
      checkOutput($sformatf("animP3_%0d", i + 1), 32'(ramAddr), 32'(animExp[i]));
    end
    writeReg(2'd2, 32'h03);
    for (int i = 0; i < 4; i++) begin
      frameTick();
      checkOutput($sformatf("animP0_%0d", i + 7), 32'(ramAddr), 32'(zeroExp[i]));
    end
    writeReg(2'd3, 32'd1);
    writeReg(2'd2, 32'd1);
    frameTick();
    step(2);
    checkOutput("manualFrame", 32'(ramAddr), 32'h400);
    frameTick();
    step();
    checkOutput("manualFrameHeld", 32'(ramAddr), 32'h400);

    // Right-edge clipping and wrap of columns left of the origin
    writeReg(2'd0, 32'd620);
    frameTick();
    applyStimulus(11'd639, 11'd50, 12'h700);
    step();
    checkOutput("edgeAddr", 32'(ramAddr), 32'h413);
    step(2);
    checkOutput("edgePixel", 32'(soRgb), 32'h0B1);
    applyStimulus(11'd620, 11'd50, 12'h701);
    step();
    checkOutput("wrapOriginAddr", 32'(ramAddr), 32'h400);
    applyStimulus(11'd0, 11'd50, 12'h777);
    step(3);
    checkOutput("wrapMissX0", 32'(soRgb), 32'h777);
    applyStimulus(11'd11, 11'd50, 12'h788);
    step(3);
    checkOutput("wrapMissX11", 32'(soRgb), 32'h788);

    // Mid-line asynchronous reset
    applyStimulus(11'd620, 11'd50, 12'h790);
    step(3);
    checkOutput("preResetHit", 32'(soRgb), 32'h0A0);
    resetN = 1'b0;
    #1;
    checkOutput("asyncResetSo", 32'(soRgb), 32'h0);
    checkOutput("asyncResetAddr", 32'(ramAddr), 32'h0);
    step();
    resetN = 1'b1;
    applyStimulus(11'd620, 11'd50, 12'h999);
    step(3);
    checkOutput("enableCleared", 32'(soRgb), 32'h999);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
